stopwatch_time_counter: RTL
===========================

Name: stopwatch_time_counter

Overview:
- Downstream consumer of the stopwatch control arbiter's enable_count / enable_pause outputs.
- Converts the control enables into elapsed time, kept as four BCD digits MM:SS from 00:00 to 59:59.
- Feeds the display driver with the digits, a one-second tick, a rollover strobe and an optional blink mask.
- Owns the clock-to-seconds prescaler, so the arbiter never handles time directly.

Parameters:
- TICK_DIV, 100000000, clk cycles per counted second; minimum 2; benches use 4.
- BLINK_DIV, 25000000, clk cycles per blank-mask toggle while paused; minimum 1; used only with BLINK_EN.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable_count  input  1  high = time advances (arbiter COUNTING).
- enable_pause  input  1  high = time frozen (arbiter PAUSED).
- min_tens  output  4  BCD minutes tens, 0..5.
- min_ones  output  4  BCD minutes ones, 0..9.
- sec_tens  output  4  BCD seconds tens, 0..5.
- sec_ones  output  4  BCD seconds ones, 0..9.
- sec_tick  output  1  one-cycle pulse on each counted second.
- rollover  output  1  one-cycle pulse on the 59:59 -> 00:00 wrap.
- blank  output  1  display blank mask; 1 = digits off.

Behaviour:
- Reset (sampled on the clk edge): all digits 0, prescaler 0, blink counter 0; sec_tick, rollover and blank all 0. Reset overrides every other input.
- All outputs are registered; there is no combinational path from the inputs to the outputs.
- The mode is decoded every cycle, with this priority:
  - COUNT: enable_count=1 and enable_pause=0.
  - HOLD: enable_pause=1, regardless of enable_count. The both-high illegal case is treated as HOLD.
  - IDLE: both enables 0 (arbiter DEFAULT state).
- IDLE: prescaler and all digits clear to 0 on the next edge; blank=0.
- HOLD: prescaler and digits keep their values, so the partial second is preserved across a pause.
- COUNT, prescaler below TICK_DIV-1: the prescaler increments by 1.
- COUNT, prescaler equal to TICK_DIV-1, on that edge:
  - prescaler becomes 0;
  - digits load the next time value;
  - sec_tick is 1 for exactly the following cycle.
- First tick latency: TICK_DIV cycles from the first COUNT cycle, counted from prescaler 0.
- Digit carry chain:
  - sec_ones 9 -> 0 and carries into sec_tens;
  - sec_tens 5 with sec_ones 9 -> both 0 and carries into min_ones;
  - min_ones 9 -> 0 and carries into min_tens;
  - 59:59 -> 00:00, and rollover is 1 for the same cycle as that sec_tick.
- sec_tick and rollover are 0 in every cycle that does not follow a tick edge.
- Digits never leave their BCD ranges. Out-of-range states are unreachable.
- Mid-count changes:
  - A COUNT -> HOLD -> COUNT sequence resumes from the preserved prescaler value.
  - A change to IDLE drops the partial second.
- Reset asserted during a tick edge wins: no tick, no rollover, all outputs 0.

Optional Feature:
- Macro: STOPWATCH_BLINK_EN.
- Defined:
  - In HOLD, a counter runs 0..BLINK_DIV-1 and blank toggles each time it wraps. The first toggle (blank 0 -> 1) happens BLINK_DIV cycles after HOLD is entered.
  - Leaving HOLD clears the counter and forces blank=0 on the next edge.
- Not defined: no blink counter exists and blank is held at constant 0.

Test Plan (TICK_DIV=4, BLINK_DIV=2):
- Reset, then COUNT for 12 cycles -> sec_tick pulses at cycles 4, 8 and 12; sec_ones reads 1, 2, 3; all other digits stay 0.
- COUNT for 2 cycles, HOLD for 10 cycles, then COUNT -> no tick during HOLD; first tick arrives 2 COUNT cycles after resume; digits read 00:01.
- Preload to 00:59 by counting, then tick -> 01:00, rollover=0. Counted to 59:59, then tick -> 00:00 with rollover=1 and sec_tick=1 in the same cycle.
- Reach 00:03, then drive IDLE for 1 cycle, then COUNT -> digits 00:00 the cycle after IDLE; next tick arrives after 4 full COUNT cycles.
- Both enables high for 8 cycles from 00:02 -> digits hold at 00:02 and no sec_tick. Reset asserted on the edge where the prescaler equals 3 -> all outputs 0 and no tick.
- With STOPWATCH_BLINK_EN, HOLD for 6 cycles -> blank goes 0, 0, 1, 1, 0, 0; on returning to COUNT, blank=0 the next cycle. Without the macro, blank stays 0 throughout.

Source files
------------

// File: rtl/stopwatch_time_counter.sv
// stopwatch_time_counter: prescaled BCD MM:SS elapsed-time counter.
// Macro STOPWATCH_BLINK_EN adds a blank-mask blinker while paused.
module stopwatch_time_counter #(
  parameter int TICK_DIV  = 100000000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable_count,
  input  logic       enable_pause,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       sec_tick,
  output logic       rollover,
  output logic       blank
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    M_IDLE,
    M_COUNT,
    M_HOLD
  } mode_t;

  mode_t         mode;
  logic [PW-1:0] presc;
  logic          tick_edge;
  logic          at_max;
  logic [3:0]    n_mt;
  logic [3:0]    n_mo;
  logic [3:0]    n_st;
  logic [3:0]    n_so;

  // Decode mode; pause dominates so both-high behaves as hold
  always_comb begin
    mode = M_IDLE;
    unique case (1'b1)
      enable_pause:                  mode = M_HOLD;
      enable_count && !enable_pause: mode = M_COUNT;
      default:                       mode = M_IDLE;
    endcase
  end

  // Next time value with BCD carry chain and 59:59 wrap
  always_comb begin
    n_so = sec_ones + 4'd1;
    n_st = sec_tens;
    n_mo = min_ones;
    n_mt = min_tens;
    if (sec_ones == 4'd9) begin
      n_so = 4'd0;
      n_st = sec_tens + 4'd1;
      if (sec_tens == 4'd5) begin
        n_st = 4'd0;
        n_mo = min_ones + 4'd1;
        if (min_ones == 4'd9) begin
          n_mo = 4'd0;
          n_mt = min_tens + 4'd1;
          if (min_tens == 4'd5) begin
            n_mt = 4'd0;
          end
        end
      end
    end
  end

  assign at_max = (min_tens == 4'd5) && (min_ones == 4'd9) &&
                  (sec_tens == 4'd5) && (sec_ones == 4'd9);

  assign tick_edge = (mode == M_COUNT) && (presc == P_LAST);

  // Prescaler, digits and the registered tick/rollover strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      presc    <= '0;
      min_tens <= 4'd0;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
      sec_tick <= 1'b0;
      rollover <= 1'b0;
    end else begin
      sec_tick <= tick_edge;
      rollover <= tick_edge && at_max;
      unique case (mode)
        M_COUNT: begin
          if (tick_edge) begin
            presc    <= '0;
            min_tens <= n_mt;
            min_ones <= n_mo;
            sec_tens <= n_st;
            sec_ones <= n_so;
          end else begin
            presc <= presc + 1'b1;
          end
        end
        M_HOLD: begin
          presc <= presc;
        end
        default: begin
          presc    <= '0;
          min_tens <= 4'd0;
          min_ones <= 4'd0;
          sec_tens <= 4'd0;
          sec_ones <= 4'd0;
        end
      endcase
    end
  end

`ifdef STOPWATCH_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] bcnt;

  // Blink while held; any other mode restarts the blink phase
  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt  <= '0;
      blank <= 1'b0;
    end else if (mode == M_HOLD) begin
      if (bcnt == B_LAST) begin
        bcnt  <= '0;
        blank <= ~blank;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end else begin
      bcnt  <= '0;
      blank <= 1'b0;
    end
  end
`else
  // No blinker: a legal BLINK_DIV always makes this constant 0
  assign blank = (BLINK_DIV < 1);
`endif

endmodule
